// File: rtl/cpu_controller_if.sv
// ---------------------------------------------------------------------------
// cpu_controller_if
// Bundles the signals between the instruction sequencer and the rest of the
// 8-bit accumulator CPU (instruction register, ALU, memory, PC).
//
//   opcode      [2:0]  opcode field of the instruction register
//   zero               accumulator-is-zero flag from the ALU
//   resume             request to leave HALT
//   rd / wr            memory read / write strobes
//   load_ir            load instruction register from the data bus
//   inc_pc / load_pc   program counter increment / load from IR address
//   alu_enable         ALU register enable
//   load_acc           accumulator load from ALU output
//   datactl_ena        drive accumulator onto the data bus
//   halt               machine halted
//   state       [3:0]  current sequencer state (debug)
//
// master: the sequencer (drives the strobes)
// slave : the datapath side (drives opcode/zero/resume)
// ---------------------------------------------------------------------------
interface cpu_controller_if;
    logic [2:0] opcode;
    logic       zero;
    logic       resume;
    logic       rd;
    logic       wr;
    logic       load_ir;
    logic       inc_pc;
    logic       load_pc;
    logic       alu_enable;
    logic       load_acc;
    logic       datactl_ena;
    logic       halt;
    logic [3:0] state;

    modport master (
        input  opcode, zero, resume,
        output rd, wr, load_ir, inc_pc, load_pc, alu_enable,
               load_acc, datactl_ena, halt, state
    );

    modport slave (
        output opcode, zero, resume,
        input  rd, wr, load_ir, inc_pc, load_pc, alu_enable,
               load_acc, datactl_ena, halt, state
    );
endinterface

// File: rtl/cpu_controller.sv
// ---------------------------------------------------------------------------
// cpu_controller
// Instruction sequencer for the 8-bit accumulator CPU. Every instruction
// walks a fixed eight-state cycle S0..S7; HLT diverts from S3 into HALT.
// All strobes are registered and decoded from the next state at the clock
// edge, so each strobe is valid for the whole cycle the FSM sits in a state.
//
// Parameters:
//   RESUME_EN  1: a resume pulse leaves HALT;  0: only rst_n leaves HALT
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset (forces IDLE, all strobes low)
//   bus    cpu_controller_if.master (opcode/zero/resume in, strobes out)
// ---------------------------------------------------------------------------
module cpu_controller #(
    parameter logic RESUME_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    cpu_controller_if.master bus
);

    // State codes
    localparam logic [3:0] S0     = 4'd0;
    localparam logic [3:0] S1     = 4'd1;
    localparam logic [3:0] S2     = 4'd2;
    localparam logic [3:0] S3     = 4'd3;
    localparam logic [3:0] S4     = 4'd4;
    localparam logic [3:0] S5     = 4'd5;
    localparam logic [3:0] S6     = 4'd6;
    localparam logic [3:0] S7     = 4'd7;
    localparam logic [3:0] IDLE   = 4'd8;
    localparam logic [3:0] HALT_S = 4'd9;

    // Opcodes
    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STA = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    // Bit positions inside the packed strobe register
    localparam int B_RD   = 8;
    localparam int B_WR   = 7;
    localparam int B_LIR  = 6;
    localparam int B_INC  = 5;
    localparam int B_LPC  = 4;
    localparam int B_ALU  = 3;
    localparam int B_LACC = 2;
    localparam int B_DCTL = 1;
    localparam int B_HALT = 0;

    logic [3:0] state_r;
    logic [3:0] next_state_s;
    logic [2:0] op_r;
    logic [8:0] strb_r;

    // Strobe pattern for the state about to be entered. op is the opcode
    // latched at the end of DECODE; z is the zero flag seen at the edge.
    function automatic logic [8:0] decode_strobes(
        input logic [3:0] st,
        input logic [2:0] op,
        input logic       z
    );
        logic [8:0] s;
        s = 9'd0;
        case (st)
            S0, S1: begin
                s[B_RD]  = 1'b1;
                s[B_LIR] = 1'b1;
                s[B_INC] = 1'b1;
            end
            S3: begin
                s[B_ALU] = 1'b1;
            end
            S4: begin
                case (op)
                    OP_ADD, OP_AND, OP_XOR, OP_LDA: s[B_RD]   = 1'b1;
                    OP_STA:                         s[B_DCTL] = 1'b1;
                    OP_JMP:                         s[B_LPC]  = 1'b1;
                    OP_SKZ:                         s[B_INC]  = z;
                    default:                        s         = 9'd0;
                endcase
            end
            S5: begin
                case (op)
                    OP_ADD, OP_AND, OP_XOR, OP_LDA: begin
                        s[B_RD]  = 1'b1;
                        s[B_ALU] = 1'b1;
                    end
                    OP_STA: begin
                        s[B_DCTL] = 1'b1;
                        s[B_WR]   = 1'b1;
                    end
                    OP_JMP:  s[B_LPC] = 1'b1;
                    default: s        = 9'd0;
                endcase
            end
            S6: begin
                case (op)
                    OP_ADD, OP_AND, OP_XOR, OP_LDA: s[B_LACC] = 1'b1;
                    OP_STA:                         s[B_DCTL] = 1'b1;
                    // second skip increment: two pulses skip a 2-byte instruction
                    OP_SKZ:                         s[B_INC]  = z;
                    default:                        s         = 9'd0;
                endcase
            end
            HALT_S: begin
                s[B_HALT] = 1'b1;
            end
            default: begin
                s = 9'd0;
            end
        endcase
        return s;
    endfunction

    // Next-state selection; illegal codes fall back to IDLE.
    always_comb begin
        next_state_s = IDLE;
        case (state_r)
            IDLE:               next_state_s = S0;
            S0, S1, S2, S4, S5, S6: next_state_s = state_r + 4'd1;
            S3: begin
                if (op_r == OP_HLT) begin
                    next_state_s = HALT_S;
                end else begin
                    next_state_s = S4;
                end
            end
            S7:                 next_state_s = S0;
            HALT_S: begin
                if ((RESUME_EN == 1'b1) && (bus.resume == 1'b1)) begin
                    next_state_s = S0;
                end else begin
                    next_state_s = HALT_S;
                end
            end
            default:            next_state_s = IDLE;
        endcase
    end

    // State register and registered strobes decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            strb_r  <= 9'd0;
        end else begin
            state_r <= next_state_s;
            strb_r  <= decode_strobes(next_state_s, op_r, bus.zero);
        end
    end

    // Opcode latch: sampled only when leaving DECODE so later IR changes
    // cannot disturb an instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r <= OP_HLT;
        end else if (state_r == S2) begin
            op_r <= bus.opcode;
        end else begin
            op_r <= op_r;
        end
    end

    assign bus.rd          = strb_r[B_RD];
    assign bus.wr          = strb_r[B_WR];
    assign bus.load_ir     = strb_r[B_LIR];
    assign bus.inc_pc      = strb_r[B_INC];
    assign bus.load_pc     = strb_r[B_LPC];
    assign bus.alu_enable  = strb_r[B_ALU];
    assign bus.load_acc    = strb_r[B_LACC];
    assign bus.datactl_ena = strb_r[B_DCTL];
    assign bus.halt        = strb_r[B_HALT];
    assign bus.state       = state_r;

endmodule

// File: tb/tb_cpu_controller.sv
// ---------------------------------------------------------------------------
// tb_cpu_controller
// Self-checking bench for cpu_controller. Two instances share stimulus:
// dut0 with RESUME_EN=1, dut1 with RESUME_EN=0. Expected per-cycle
// {state, strobes} vectors are pushed to a queue as each instruction is
// issued and popped/compared when the DUT reaches that cycle.
// Vector layout: {state[3:0], rd, wr, load_ir, inc_pc, load_pc,
//                 alu_enable, load_acc, datactl_ena, halt}
// ---------------------------------------------------------------------------
module tb_cpu_controller;

    localparam logic [2:0] HLT = 3'b000;
    localparam logic [2:0] SKZ = 3'b001;
    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] ANDO = 3'b011;
    localparam logic [2:0] XORO = 3'b100;
    localparam logic [2:0] LDA = 3'b101;
    localparam logic [2:0] STA = 3'b110;
    localparam logic [2:0] JMP = 3'b111;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    logic [12:0] exp_q[$];
    logic [12:0] obs0;
    logic [12:0] obs1;

    cpu_controller_if bus0 ();
    cpu_controller_if bus1 ();

    cpu_controller #(.RESUME_EN(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.master));
    cpu_controller #(.RESUME_EN(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.master));

    assign bus1.opcode = bus0.opcode;
    assign bus1.zero   = bus0.zero;
    assign bus1.resume = bus0.resume;

    assign obs0 = {bus0.state, bus0.rd, bus0.wr, bus0.load_ir, bus0.inc_pc, bus0.load_pc,
                   bus0.alu_enable, bus0.load_acc, bus0.datactl_ena, bus0.halt};
    assign obs1 = {bus1.state, bus1.rd, bus1.wr, bus1.load_ir, bus1.inc_pc, bus1.load_pc,
                   bus1.alu_enable, bus1.load_acc, bus1.datactl_ena, bus1.halt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: what each signal should be while sitting in state st.
    function automatic logic [12:0] model(input logic [3:0] st, input logic [2:0] op, input logic z);
        logic aop, rd, wr, lir, inc, lpc, alu, lacc, dctl, hlt;
        aop  = (op == ADD) || (op == ANDO) || (op == XORO) || (op == LDA);
        rd   = (st <= 4'd1) || (aop && ((st == 4'd4) || (st == 4'd5)));
        wr   = (op == STA) && (st == 4'd5);
        lir  = (st <= 4'd1);
        inc  = (st <= 4'd1) || ((op == SKZ) && z && ((st == 4'd4) || (st == 4'd6)));
        lpc  = (op == JMP) && ((st == 4'd4) || (st == 4'd5));
        alu  = (st == 4'd3) || (aop && (st == 4'd5));
        lacc = aop && (st == 4'd6);
        dctl = (op == STA) && (st >= 4'd4) && (st <= 4'd6);
        hlt  = (st == 4'd9);
        return {st, rd, wr, lir, inc, lpc, alu, lacc, dctl, hlt};
    endfunction

    // Queue the expected cycles of one instruction (HLT stops after S3).
    task automatic push_instr(input logic [2:0] op, input logic z);
        int last;
        last = (op == HLT) ? 3 : 7;
        for (int s = 0; s <= last; s++) begin
            exp_q.push_back(model(4'(s), op, z));
        end
    endtask

    task automatic test_reset();
        logic [12:0] e;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (obs0 !== {4'd8, 9'd0}) begin
            n_fail++; $display("FAIL reset_hold: got %h expected %h", obs0, {4'd8, 9'd0});
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs0 !== {4'd8, 9'd0}) begin
            n_fail++; $display("FAIL idle_after_release: got %h expected %h", obs0, {4'd8, 9'd0});
        end
        // Run an STA up to S5, then reset asynchronously mid-cycle
        bus0.opcode = STA;
        bus0.zero   = 1'b0;
        for (int s = 0; s <= 5; s++) exp_q.push_back(model(4'(s), STA, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(posedge clk); @(negedge clk);
            n_checks++;
            if (obs0 !== e) begin
                n_fail++; $display("FAIL reset_sta_lead: got %h expected %h", obs0, e);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs0 !== {4'd8, 9'd0}) begin
            n_fail++; $display("FAIL async_reset: got %h expected %h", obs0, {4'd8, 9'd0});
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs0 !== {4'd8, 9'd0}) begin
            n_fail++; $display("FAIL idle_rerelease: got %h expected %h", obs0, {4'd8, 9'd0});
        end
    endtask

    task automatic test_lda();
        logic [12:0] e;
        bus0.opcode = LDA;
        bus0.zero   = 1'b0;
        push_instr(LDA, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(posedge clk); @(negedge clk);
            n_checks++;
            if (obs0 !== e) begin
                n_fail++; $display("FAIL lda: got %h expected %h", obs0, e);
            end
            // IR change after DECODE must not turn this into a JMP
            if (e[12:9] == 4'd4) bus0.opcode = JMP;
        end
    endtask

    task automatic test_sta();
        logic [12:0] e;
        bus0.opcode = STA;
        bus0.zero   = 1'b1;
        push_instr(STA, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(posedge clk); @(negedge clk);
            n_checks++;
            if (obs0 !== e) begin
                n_fail++; $display("FAIL sta: got %h expected %h", obs0, e);
            end
        end
    endtask

    task automatic test_skz();
        logic [12:0] e;
        int          incs;
        for (int zi = 1; zi >= 0; zi--) begin
            bus0.opcode = SKZ;
            bus0.zero   = 1'(zi);
            push_instr(SKZ, 1'(zi));
            incs = 0;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                @(posedge clk); @(negedge clk);
                if (bus0.inc_pc === 1'b1) incs++;
                n_checks++;
                if (obs0 !== e) begin
                    n_fail++; $display("FAIL skz_z%0d: got %h expected %h", zi, obs0, e);
                end
            end
            n_checks++;
            if (incs !== ((zi == 1) ? 4 : 2)) begin
                n_fail++; $display("FAIL skz_inc_count_z%0d: got %0d expected %0d", zi, incs, (zi == 1) ? 4 : 2);
            end
        end
    endtask

    task automatic test_jmp();
        logic [12:0] e;
        bus0.opcode = JMP;
        bus0.zero   = 1'b1;
        push_instr(JMP, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(posedge clk); @(negedge clk);
            n_checks++;
            if (obs0 !== e) begin
                n_fail++; $display("FAIL jmp: got %h expected %h", obs0, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] e;
        logic [2:0]  ops[6];
        logic        z;
        ops = '{ADD, ANDO, XORO, STA, SKZ, LDA};
        bus0.resume = 1'b1;   // must be ignored outside HALT
        for (int k = 0; k < 6; k++) begin
            z = 1'($urandom_range(1, 0));
            bus0.opcode = ops[k];
            bus0.zero   = z;
            push_instr(ops[k], z);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                @(posedge clk); @(negedge clk);
                n_checks++;
                if (obs0 !== e) begin
                    n_fail++; $display("FAIL b2b_dut0 op%0d: got %h expected %h", k, obs0, e);
                end
                n_checks++;
                if (obs1 !== e) begin
                    n_fail++; $display("FAIL b2b_dut1 op%0d: got %h expected %h", k, obs1, e);
                end
                n_checks++;
                if (((bus0.rd & bus0.wr) | (bus0.load_pc & bus0.inc_pc)) !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_exclusive: rd=%b wr=%b load_pc=%b inc_pc=%b required no overlap",
                                       bus0.rd, bus0.wr, bus0.load_pc, bus0.inc_pc);
                end
            end
        end
        bus0.resume = 1'b0;
    endtask

    task automatic test_hlt();
        logic [12:0] e;
        bus0.opcode = HLT;
        bus0.zero   = 1'b0;
        bus0.resume = 1'b0;
        push_instr(HLT, 1'b0);
        for (int i = 0; i < 20; i++) exp_q.push_back(model(4'd9, HLT, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(posedge clk); @(negedge clk);
            n_checks++;
            if (obs0 !== e) begin
                n_fail++; $display("FAIL hlt_dut0: got %h expected %h", obs0, e);
            end
            n_checks++;
            if (obs1 !== e) begin
                n_fail++; $display("FAIL hlt_dut1: got %h expected %h", obs1, e);
            end
        end
        // Resume pulse: dut0 restarts, dut1 (RESUME_EN=0) stays halted
        bus0.opcode = LDA;
        bus0.resume = 1'b1;
        @(posedge clk); #1 bus0.resume = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs0 !== model(4'd0, LDA, 1'b0)) begin
            n_fail++; $display("FAIL resume_s0: got %h expected %h", obs0, model(4'd0, LDA, 1'b0));
        end
        n_checks++;
        if (obs1 !== model(4'd9, HLT, 1'b0)) begin
            n_fail++; $display("FAIL no_resume_en0: got %h expected %h", obs1, model(4'd9, HLT, 1'b0));
        end
        for (int s = 1; s <= 7; s++) exp_q.push_back(model(4'(s), LDA, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(posedge clk); @(negedge clk);
            n_checks++;
            if (obs0 !== e) begin
                n_fail++; $display("FAIL post_resume_lda: got %h expected %h", obs0, e);
            end
            n_checks++;
            if (obs1 !== model(4'd9, HLT, 1'b0)) begin
                n_fail++; $display("FAIL dut1_stays_halted: got %h expected %h", obs1, model(4'd9, HLT, 1'b0));
            end
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        bus0.opcode = STA;
        bus0.zero   = 1'b0;
        bus0.resume = 1'b0;
        test_reset();
        test_lda();
        test_sta();
        test_skz();
        test_jmp();
        test_back_to_back();
        test_hlt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Instruction sequencer for the 8-bit accumulator CPU.
- Sits directly upstream of the ALU. It issues `alu_enable` and all fetch, load and store strobes, driven by the 3-bit opcode from the instruction register and the ALU `zero` flag.
- Each instruction takes a fixed 8-state cycle. HLT parks the machine until it is resumed or reset.

Parameters:
- RESUME_EN, 1, 1 = `resume` pulse exits HALT; 0 = only `rst_n` exits HALT.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- opcode  input  3  opcode from IR (HLT=000 SKZ=001 ADD=010 AND=011 XOR=100 LDA=101 STA=110 JMP=111)
- zero  input  1  accumulator-is-zero flag from ALU
- resume  input  1  leave HALT (ignored unless RESUME_EN=1)
- rd  output  1  memory read strobe
- wr  output  1  memory write strobe
- load_ir  output  1  IR load (instruction byte on bus)
- inc_pc  output  1  PC increment
- load_pc  output  1  PC load from IR address field
- alu_enable  output  1  ALU register enable
- load_acc  output  1  accumulator load from alu_out
- datactl_ena  output  1  drive accumulator onto data bus
- halt  output  1  machine halted
- state  output  4  current state code (debug)

Behaviour:
- Reset (async, `rst_n`=0): state=IDLE(4'd8). All outputs 0 immediately and held while `rst_n`=0, including mid-instruction.
- All outputs are registered. They are decoded from next-state at the edge, so each strobe is valid for the full cycle the FSM occupies the listed state.
- IDLE: one cycle after reset release, then S0.
- S0 FETCH_HI: `rd`=1, `load_ir`=1, `inc_pc`=1.
- S1 FETCH_LO: `rd`=1, `load_ir`=1, `inc_pc`=1.
- S2 DECODE: no strobes. `opcode` is captured into an internal op_q at the end of S2. S3-S7 use op_q only, so IR changes after S2 have no effect.
- S3 EXEC:
  - `alu_enable`=1 for every opcode.
  - If op_q=HLT, next state is HALT. Otherwise next state is S4.
- S4 (by op_q):
  - ADD/AND/XOR/LDA: `rd`=1.
  - STA: `datactl_ena`=1.
  - JMP: `load_pc`=1.
  - SKZ: `inc_pc`=`zero` (zero sampled in S4).
- S5 (by op_q):
  - ADD/AND/XOR/LDA: `rd`=1, `alu_enable`=1 (ALU latches data+accum).
  - STA: `datactl_ena`=1, `wr`=1.
  - JMP: `load_pc`=1.
  - SKZ: none.
- S6 (by op_q):
  - ADD/AND/XOR/LDA: `load_acc`=1.
  - STA: `datactl_ena`=1.
  - SKZ: `inc_pc`=`zero` (re-sampled in S6; the two increments skip one 2-byte instruction).
  - JMP: none.
- S7: no strobes. Next state is S0.
- HALT (4'd9): `halt`=1, all other outputs 0.
  - Stays in HALT while `resume`=0.
  - `resume`=1 with RESUME_EN=1 → S0 at the next edge; `halt` drops in S0.
  - `resume`=1 in any other state is ignored.
- `wr` and `rd` are never asserted in the same cycle. `load_pc` and `inc_pc` are never asserted in the same cycle.
- State encoding: S0-S7 = 4'd0-4'd7, IDLE=8, HALT=9. Codes 10-15 are illegal and go to IDLE with all outputs 0.
- Instruction length: every non-HLT instruction takes exactly 8 cycles, S0 to S7.
- SKZ always spends S4-S6 whether or not `zero` is set.

Test Plan:
- Reset: assert `rst_n`=0 mid-S5 of an STA → `wr`/`datactl_ena` fall to 0 without waiting for `clk`, state=8. Release `rst_n` → IDLE for 1 cycle, then S0 with `rd`=`load_ir`=`inc_pc`=1.
- LDA (opcode=101): `rd` high in S0,S1,S4,S5; `alu_enable` in S3,S5; `load_acc` only in S6; next S0 exactly 8 cycles after the previous S0. Change `opcode` to 111 during S4 → no `load_pc`.
- STA (110): `datactl_ena`=1 in S4-S6, `wr`=1 only in S5, `rd`=0 in S4-S7.
- SKZ (001): with `zero`=1, `inc_pc` is high in S0,S1,S4,S6 (4 pulses per instruction). With `zero`=0, `inc_pc` is high in S0,S1 only.
- JMP (111): `load_pc`=1 in S4 and S5, `inc_pc`=0 there.
- HLT (000): `halt`=1 from the cycle after S3, all strobes 0 for 20 cycles. Pulse `resume` → S0 next cycle, `halt`=0. With RESUME_EN=0 the same pulse leaves the FSM in HALT.
